// File: rtl/elevator_pkg.sv
// Shared types and constants for the single-car LOOK elevator dispatcher.
package elevator_pkg;

  typedef enum logic [1:0] {
    SIM_STOP  = 2'b00,
    SIM_RUN   = 2'b01,
    SIM_PAUSE = 2'b10,
    SIM_FLUSH = 2'b11
  } sim_state_t;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    MOVING    = 2'b01,
    CHECK     = 2'b10,
    DOOR_OPEN = 2'b11
  } dispatch_state_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/dispatch_target_select.sv
// Combinational stop finder: are there pending stops above, below or at the car floor.
module dispatch_target_select #(
  parameter int unsigned FLOORS = 12,
  parameter int unsigned FW     = $clog2(FLOORS)
) (
  input  logic [FLOORS-1:0] pending,
  input  logic [FW-1:0]     cur_floor,
  output logic              any_above,
  output logic              any_below,
  output logic              hit_here
);

  logic [FLOORS-1:0] w_at_mask;
  logic [FLOORS-1:0] w_below_mask;
  logic [FLOORS-1:0] w_above_mask;

  // Masks split the floor vector into below / at / above the car
  always_comb begin
    w_at_mask    = FLOORS'(1) << cur_floor;
    w_below_mask = w_at_mask - FLOORS'(1);
    w_above_mask = ~(w_below_mask | w_at_mask);
    any_above    = |(pending & w_above_mask);
    any_below    = |(pending & w_below_mask);
    hit_here     = |(pending & w_at_mask);
  end

endmodule

// File: rtl/elevator_dispatch.sv
// Single-car LOOK scheduler: latches calls, moves the car, runs the doors, reports served floors.
// Optional statistics outputs (stops_served, floors_travelled) built when DISPATCH_STATS_EN is defined.
module elevator_dispatch
  import elevator_pkg::*;
#(
  parameter int unsigned FLOORS      = 12,
  parameter int unsigned FW          = $clog2(FLOORS),
  parameter int unsigned FLOOR_TICKS = 4,
  parameter int unsigned DOOR_TICKS  = 3,
  parameter int unsigned STAT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  sim_state_t        sim_state,
  input  logic              tick,
  input  logic [FLOORS-1:0] floors_requested,
  input  logic [FLOORS-1:0] floor_destinations,
  output logic [FLOORS-1:0] pending,
  output logic [FW-1:0]     cur_floor,
  output logic              direction,
  output logic              moving,
  output logic              door_open,
  output logic [FLOORS-1:0] served
`ifdef DISPATCH_STATS_EN
  ,
  output logic [STAT_W-1:0] stops_served,
  output logic [STAT_W-1:0] floors_travelled
`endif
);

  localparam int unsigned TW = $clog2(FLOOR_TICKS + 1);
  localparam int unsigned DW = $clog2(DOOR_TICKS + 1);

  if (FLOOR_TICKS < 1 || DOOR_TICKS < 1 || STAT_W < 1) begin : g_param_check
    $error("elevator_dispatch: FLOOR_TICKS, DOOR_TICKS and STAT_W must be >= 1");
  end

  dispatch_state_t   r_state, w_state_nxt;
  logic [TW-1:0]     r_travel_cnt, w_travel_nxt;
  logic [DW-1:0]     r_door_cnt, w_door_nxt;
  logic [FW-1:0]     r_floor, w_floor_nxt;
  logic              r_dir, w_dir_nxt;
  logic [FLOORS-1:0] r_pending, w_pending_nxt;
  logic [FLOORS-1:0] r_served;
  logic              r_moving, r_door_open;
  logic [FLOORS-1:0] w_clear;
  logic [FLOORS-1:0] w_req;
  logic [FLOORS-1:0] w_at_mask;
  logic              w_any_above, w_any_below, w_hit_here;
  logic              w_ahead, w_behind;
  dispatch_state_t   w_leave_state;
  logic              w_leave_dir;

  dispatch_target_select #(
    .FLOORS (FLOORS),
    .FW     (FW)
  ) u_target_select (
    .pending   (r_pending),
    .cur_floor (r_floor),
    .any_above (w_any_above),
    .any_below (w_any_below),
    .hit_here  (w_hit_here)
  );

  assign w_req     = floors_requested | floor_destinations;
  assign w_at_mask = FLOORS'(1) << r_floor;
  assign w_ahead   = (r_dir == DIR_UP) ? w_any_above : w_any_below;
  assign w_behind  = (r_dir == DIR_UP) ? w_any_below : w_any_above;

  // Where to go once nothing remains at this floor: keep going, reverse, or park
  assign w_leave_state = (w_ahead || w_behind) ? MOVING : IDLE;
  assign w_leave_dir   = (!w_ahead && w_behind) ? ~r_dir : r_dir;

  // Next-state, counters, floor/direction and stop clearing
  always_comb begin
    w_state_nxt  = r_state;
    w_travel_nxt = r_travel_cnt;
    w_door_nxt   = r_door_cnt;
    w_floor_nxt  = r_floor;
    w_dir_nxt    = r_dir;
    w_clear      = '0;

    if (sim_state == SIM_FLUSH) begin
      w_state_nxt  = IDLE;
      w_travel_nxt = '0;
      w_door_nxt   = '0;
    end else if (sim_state == SIM_RUN) begin
      unique case (r_state)
        IDLE: begin
          if (|r_pending) begin
            if (w_hit_here) begin
              w_state_nxt = DOOR_OPEN;
              w_clear     = w_at_mask;
            end else begin
              w_state_nxt = w_leave_state;
              w_dir_nxt   = w_leave_dir;
            end
          end
        end
        MOVING: begin
          if (tick) begin
            if (r_travel_cnt == TW'(FLOOR_TICKS - 1)) begin
              w_travel_nxt = '0;
              w_state_nxt  = CHECK;
              if (r_dir == DIR_UP) begin
                if (r_floor != FW'(FLOORS - 1)) w_floor_nxt = r_floor + FW'(1);
              end else begin
                if (r_floor != '0) w_floor_nxt = r_floor - FW'(1);
              end
            end else begin
              w_travel_nxt = r_travel_cnt + TW'(1);
            end
          end
        end
        CHECK: begin
          if (w_hit_here) begin
            w_state_nxt = DOOR_OPEN;
            w_clear     = w_at_mask;
          end else begin
            w_state_nxt = w_leave_state;
            w_dir_nxt   = w_leave_dir;
          end
        end
        DOOR_OPEN: begin
          // Any call for this floor while the door is open restarts the dwell
          if (w_hit_here || |(w_req & w_at_mask)) begin
            w_clear    = w_at_mask;
            w_door_nxt = '0;
          end else if (tick) begin
            if (r_door_cnt == DW'(DOOR_TICKS - 1)) begin
              w_door_nxt  = '0;
              w_state_nxt = w_leave_state;
              w_dir_nxt   = w_leave_dir;
            end else begin
              w_door_nxt = r_door_cnt + DW'(1);
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end

    // The car can only head away from the end floors
    if (w_floor_nxt == '0) begin
      w_dir_nxt = DIR_UP;
    end else if (w_floor_nxt == FW'(FLOORS - 1)) begin
      w_dir_nxt = DIR_DN;
    end

    unique case (sim_state)
      SIM_FLUSH:          w_pending_nxt = '0;
      SIM_RUN, SIM_PAUSE: w_pending_nxt = (r_pending | w_req) & ~w_clear;
      default:            w_pending_nxt = r_pending;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_travel_cnt <= '0;
      r_door_cnt   <= '0;
      r_floor      <= '0;
      r_dir        <= DIR_UP;
      r_pending    <= '0;
      r_served     <= '0;
      r_moving     <= 1'b0;
      r_door_open  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_travel_cnt <= w_travel_nxt;
      r_door_cnt   <= w_door_nxt;
      r_floor      <= w_floor_nxt;
      r_dir        <= w_dir_nxt;
      r_pending    <= w_pending_nxt;
      r_served     <= w_clear;
      r_moving     <= (w_state_nxt == MOVING);
      r_door_open  <= (w_state_nxt == DOOR_OPEN);
    end
  end

  assign pending   = r_pending;
  assign cur_floor = r_floor;
  assign direction = r_dir;
  assign moving    = r_moving;
  assign door_open = r_door_open;
  assign served    = r_served;

`ifdef DISPATCH_STATS_EN
  logic [STAT_W-1:0] r_stops_served;
  logic [STAT_W-1:0] r_floors_travelled;

  // Saturating statistics, cleared by reset and by a flush
  always_ff @(posedge clk) begin
    if (rst || sim_state == SIM_FLUSH) begin
      r_stops_served     <= '0;
      r_floors_travelled <= '0;
    end else begin
      if (|w_clear && r_stops_served != '1) begin
        r_stops_served <= r_stops_served + STAT_W'(1);
      end
      if (w_floor_nxt != r_floor && r_floors_travelled != '1) begin
        r_floors_travelled <= r_floors_travelled + STAT_W'(1);
      end
    end
  end

  assign stops_served     = r_stops_served;
  assign floors_travelled = r_floors_travelled;
`else
  // Statistics counters are not built in this configuration
`endif

endmodule
